// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches words over a req/valid handshake,
// and presents the decoded fields of one instruction at a time to the control unit.
module fetch_unit #(
   parameter int              PC_W     = 16,
   parameter int              INST_W   = 32,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic              stall,
   input  logic              redirect_en,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic              imem_req,
   output logic [PC_W-1:0]   imem_addr,
   input  logic              imem_valid,
   input  logic [INST_W-1:0] imem_rdata,
   output logic              inst_valid,
   output logic [PC_W-1:0]   inst_pc,
   output logic [5:0]        opcode,
   output logic [3:0]        rd,
   output logic [3:0]        ra,
   output logic [3:0]        rb,
   output logic [15:0]       imm
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_ISSUE
   } state_t;

   state_t              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [PC_W-1:0]     addr_q, addr_d;
   logic                discard_q, discard_d;
   logic [INST_W-1:0]   ir_q, ir_d;
   logic [PC_W-1:0]     inst_pc_q, inst_pc_d;
   logic [PC_W-1:0]     pc_inc;

   assign pc_inc = pc_q + {{(PC_W-1){1'b0}}, 1'b1};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         addr_q    <= RESET_PC;
         discard_q <= 1'b0;
         ir_q      <= '0;
         inst_pc_q <= RESET_PC;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         addr_q    <= addr_d;
         discard_q <= discard_d;
         ir_q      <= ir_d;
         inst_pc_q <= inst_pc_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      addr_d    = addr_q;
      discard_d = discard_q;
      ir_d      = ir_q;
      inst_pc_d = inst_pc_q;

      case (state_q)
         S_IDLE: begin
            if (redirect_en) pc_d = redirect_pc;
            if (run) state_d = S_FETCH;
         end

         S_FETCH: begin
            // The request address is frozen here so a redirect can move pc
            // without disturbing the fetch already on the bus.
            addr_d  = pc_q;
            state_d = S_WAIT;
            if (redirect_en) begin
               pc_d      = redirect_pc;
               discard_d = 1'b1;
            end
         end

         S_WAIT: begin
            if (redirect_en) begin
               pc_d = redirect_pc;
               if (imem_valid) begin
                  discard_d = 1'b0;
                  state_d   = S_FETCH;
               end else begin
                  discard_d = 1'b1;
               end
            end else if (imem_valid) begin
               if (discard_q) begin
                  discard_d = 1'b0;
                  state_d   = run ? S_FETCH : S_IDLE;
               end else begin
                  ir_d      = imem_rdata;
                  inst_pc_d = pc_q;
                  pc_d      = pc_inc;
                  state_d   = S_ISSUE;
               end
            end
         end

         S_ISSUE: begin
            // A taken branch overrides a downstream stall.
            if (redirect_en) begin
               pc_d    = redirect_pc;
               state_d = run ? S_FETCH : S_IDLE;
            end else if (!stall) begin
               state_d = run ? S_FETCH : S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign imem_req   = (state_q == S_FETCH) || (state_q == S_WAIT);
   assign imem_addr  = (state_q == S_FETCH) ? pc_q : addr_q;
   assign inst_valid = (state_q == S_ISSUE);
   assign inst_pc    = inst_pc_q;

   // Opcode collapses to NOP whenever nothing valid is presented.
   assign opcode = inst_valid ? ir_q[31:26] : 6'b000000;
   assign rd     = ir_q[25:22];
   assign ra     = ir_q[21:18];
   assign rb     = ir_q[17:14];
   assign imm    = ir_q[15:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed handshake/stall/redirect/wrap/reset scenarios, then random
// traffic checked against a program-order model of the issued instruction stream.
module tb_fetch_unit;
   localparam int              PC_W     = 16;
   localparam int              INST_W   = 32;
   localparam logic [PC_W-1:0] RESET_PC = 16'h0000;

   logic              clk;
   logic              rst_n;
   logic              run;
   logic              stall;
   logic              redirect_en;
   logic [PC_W-1:0]   redirect_pc;
   logic              imem_req;
   logic [PC_W-1:0]   imem_addr;
   logic              imem_valid;
   logic [INST_W-1:0] imem_rdata;
   logic              inst_valid;
   logic [PC_W-1:0]   inst_pc;
   logic [5:0]        opcode;
   logic [3:0]        rd;
   logic [3:0]        ra;
   logic [3:0]        rb;
   logic [15:0]       imm;

   int n_vec     = 0;
   int n_err     = 0;
   int n_present = 0;

   // Memory responder state (owned by the stimulus process).
   int age        = 0;
   int lat        = 0;
   int lat_fix    = 0;
   bit lat_rand   = 0;
   bit force_pulse = 0;

   // Expected PC of the next instruction to be presented, in program order.
   logic [PC_W-1:0] exp_q [$];

   fetch_unit #(
      .PC_W     (PC_W),
      .INST_W   (INST_W),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (run),
      .stall       (stall),
      .redirect_en (redirect_en),
      .redirect_pc (redirect_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_valid  (imem_valid),
      .imem_rdata  (imem_rdata),
      .inst_valid  (inst_valid),
      .inst_pc     (inst_pc),
      .opcode      (opcode),
      .rd          (rd),
      .ra          (ra),
      .rb          (rb),
      .imm         (imm)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      logic [31:0] x;
      if (a == 16'h0000) return 32'h0440_0000;
      x = {16'h0000, a} * 32'h9E37_79B1;
      return x ^ {a, ~a};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock: wait for the edge, then drive inputs and the memory model.
   task automatic cyc();
      @(posedge clk);
      #1;
      imem_valid = 1'b0;
      imem_rdata = $urandom();
      if (force_pulse) begin
         imem_valid  = 1'b1;
         force_pulse = 1'b0;
      end else if (!imem_req) begin
         age = 0;
      end else begin
         age++;
         if (age >= 2 + lat) begin
            imem_valid = 1'b1;
            imem_rdata = mem_word(imem_addr);
            age        = 0;
            lat        = lat_rand ? int'($urandom_range(0, 2)) : lat_fix;
         end
      end
   endtask

   // Monitor / scoreboard.
   initial begin : monitor
      logic            held;
      logic [49:0]     held_val;
      logic [49:0]     cur;
      logic            prev_req;
      logic            prev_valid;
      logic [PC_W-1:0] prev_addr;
      logic [PC_W-1:0] e;
      logic [31:0]     w;
      held = 1'b0; held_val = '0; prev_req = 1'b0; prev_valid = 1'b0; prev_addr = '0;
      forever begin
         @(negedge clk);
         cur = {inst_pc, opcode, rd, ra, rb, imm};
         if (!rst_n) begin
            chk("rst_iv", 64'(inst_valid), 64'(0));
            exp_q.delete();
            exp_q.push_back(RESET_PC);
            held     = 1'b0;
            prev_req = 1'b0;
         end else begin
            if (!inst_valid) chk("nop_opcode", 64'(opcode), 64'(0));
            if (held) begin
               chk("stall_hold", 64'({inst_valid, cur}), 64'({1'b1, held_val}));
            end else if (inst_valid) begin
               n_present++;
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL issue: got pc %h expected nothing queued", inst_pc);
               end else begin
                  e = exp_q.pop_front();
                  w = mem_word(e);
                  chk("issue", 64'(cur), 64'({e, w[31:26], w[25:22], w[21:18], w[17:14], w[15:0]}));
                  exp_q.push_back(e + 16'd1);
               end
            end
            if (inst_valid) chk("issue_noreq", 64'(imem_req), 64'(0));
            if (prev_req && !prev_valid && imem_req)
               chk("addr_stable", 64'(imem_addr), 64'(prev_addr));
            if (redirect_en) begin
               exp_q.delete();
               exp_q.push_back(redirect_pc);
            end
            held       = inst_valid && stall && !redirect_en;
            held_val   = cur;
            prev_req   = imem_req;
            prev_valid = imem_valid;
            prev_addr  = imem_addr;
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, got %0d vectors expected completion", n_vec);
      $fatal(1, "timeout");
   end

   initial begin : stim
      rst_n = 1'b0; run = 1'b0; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
      imem_valid = 1'b0; imem_rdata = '0;
      repeat (3) cyc();
      chk("rst_req",    64'(imem_req),   64'(0));
      chk("rst_addr",   64'(imem_addr),  64'(RESET_PC));
      chk("rst_fields", 64'({inst_valid, inst_pc, opcode, rd, ra, rb, imm}), 64'({1'b0, RESET_PC, 34'h0}));

      // Basic fetch, 1-cycle latency, 3-cycle throughput.
      rst_n = 1'b1;
      cyc();
      chk("idle_noreq", 64'(imem_req), 64'(0));
      run = 1'b1;
      cyc(); chk("t1_req",       64'({imem_req, imem_addr}), 64'({1'b1, 16'h0000}));
      cyc(); chk("t1_wait_iv",   64'(inst_valid), 64'(0));
      cyc(); chk("t1_issue",     64'({inst_valid, opcode, rd, inst_pc}), 64'({1'b1, 6'd1, 4'd1, 16'h0000}));
      cyc(); chk("t1_next_addr", 64'({imem_req, imem_addr, inst_valid}), 64'({1'b1, 16'h0001, 1'b0}));

      // Stall held 4 cycles in ISSUE.
      cyc(); cyc();
      chk("t2_issue", 64'({inst_valid, inst_pc}), 64'({1'b1, 16'h0001}));
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("t2_stall", 64'({inst_valid, imem_req, inst_pc}), 64'({1'b1, 1'b0, 16'h0001}));
      end
      stall = 1'b0;
      cyc(); chk("t2_resume", 64'({imem_req, imem_addr}), 64'({1'b1, 16'h0002}));

      // Redirect in WAIT, stale data 2 cycles later.
      lat = 2;
      cyc();
      redirect_en = 1'b1; redirect_pc = 16'h0100;
      cyc(); redirect_en = 1'b0;
      chk("t3_wait", 64'({imem_req, imem_addr, inst_valid}), 64'({1'b1, 16'h0002, 1'b0}));
      cyc(); chk("t3_stale_iv", 64'(inst_valid), 64'(0));
      cyc(); chk("t3_refetch", 64'({imem_req, imem_addr, inst_valid}), 64'({1'b1, 16'h0100, 1'b0}));

      // Redirect and imem_valid in the same cycle.
      cyc();
      redirect_en = 1'b1; redirect_pc = 16'h0200;
      cyc(); redirect_en = 1'b0;
      chk("t4_fetch", 64'({imem_req, imem_addr, inst_valid}), 64'({1'b1, 16'h0200, 1'b0}));
      cyc(); cyc();
      chk("t4_issue", 64'({inst_valid, inst_pc}), 64'({1'b1, 16'h0200}));

      // PC wrap from 0xFFFF, redirect from ISSUE.
      redirect_en = 1'b1; redirect_pc = 16'hFFFF;
      cyc(); redirect_en = 1'b0;
      chk("t5_fetch", 64'({imem_req, imem_addr, inst_valid}), 64'({1'b1, 16'hFFFF, 1'b0}));
      cyc(); cyc();
      chk("t5_issue", 64'({inst_valid, inst_pc}), 64'({1'b1, 16'hFFFF}));
      cyc(); chk("t5_wrap", 64'({imem_req, imem_addr}), 64'({1'b1, 16'h0000}));

      // Reset pulsed in WAIT, stray valid in IDLE afterwards.
      lat = 3;
      cyc();
      chk("t6_wait", 64'({imem_req, inst_pc}), 64'({1'b1, 16'hFFFF}));
      rst_n = 1'b0;
      #1;
      chk("t6_rst_async", 64'({imem_req, imem_addr, inst_valid, inst_pc, opcode, rd, ra, rb, imm}),
          64'({1'b0, RESET_PC, 1'b0, RESET_PC, 34'h0}));
      run = 1'b0; lat = 0;
      cyc(); cyc();
      rst_n = 1'b1;
      force_pulse = 1'b1;
      cyc(); chk("t7_idle",  64'({imem_req, inst_valid, opcode}), 64'(0));
      cyc(); chk("t7_idle2", 64'({imem_req, inst_valid}), 64'(0));
      run = 1'b1;
      cyc(); chk("t7_fetch", 64'({imem_req, imem_addr}), 64'({1'b1, RESET_PC}));
      cyc(); cyc();
      chk("t7_issue", 64'({inst_valid, inst_pc}), 64'({1'b1, RESET_PC}));

      // Randomized traffic.
      lat_rand = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         run         = ($urandom_range(0, 15) != 0);
         stall       = ($urandom_range(0, 2) == 0);
         redirect_en = ($urandom_range(0, 11) == 0);
         case ($urandom_range(0, 3))
            0:       redirect_pc = 16'hFFFE;
            1:       redirect_pc = 16'hFFFF;
            default: redirect_pc = 16'($urandom());
         endcase
         rst_n = ($urandom_range(0, 499) != 0);
         cyc();
      end
      run = 1'b1; stall = 1'b0; redirect_en = 1'b0; rst_n = 1'b1;
      repeat (10) cyc();
      chk("min_issued", 64'(n_present >= 100), 64'(1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control unit.
- Holds the PC and requests instruction words from instruction memory over a req/valid handshake.
- Latches each returned word into an instruction register and splits it into opcode, register and immediate fields for the control unit and register file.
- Supports stall from downstream and PC redirect (jump/branch) with discard of in-flight fetches.

Parameters:
- PC_W, 16, PC and imem address width; word-addressed.
- INST_W, 32, instruction word width.
- RESET_PC, 0, PC value loaded at reset.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  fetch enable; low stops new fetches.
- stall  in  1  downstream not ready; holds the current instruction.
- redirect_en  in  1  load a new PC (jump/branch taken).
- redirect_pc  in  PC_W  target PC.
- imem_req  out  1  fetch request, level-held until accepted.
- imem_addr  out  PC_W  fetch address; stable while imem_req is high.
- imem_valid  in  1  read data valid; one-cycle pulse.
- imem_rdata  in  INST_W  instruction word.
- inst_valid  out  1  decoded fields valid this cycle.
- inst_pc  out  PC_W  PC of the presented instruction.
- opcode  out  6  bits [31:26]; forced to 6'b000000 (NOP) whenever inst_valid=0.
- rd  out  4  bits [25:22].
- ra  out  4  bits [21:18].
- rb  out  4  bits [17:14].
- imm  out  16  bits [15:0].

Behaviour:
- Reset (async assert, sync release) sets:
  - pc=RESET_PC, state IDLE, discard=0.
  - imem_req=0, imem_addr=RESET_PC, inst_valid=0.
  - opcode=0, rd=0, ra=0, rb=0, imm=0, inst_pc=RESET_PC.
- Reset mid-fetch abandons the request. Any imem_valid arriving after reset in IDLE is ignored.
- FSM states: IDLE, FETCH, WAIT, ISSUE.
- IDLE:
  - imem_req=0.
  - Go to FETCH when run=1.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - Go to WAIT next cycle.
- WAIT:
  - imem_req stays 1, addr held.
  - On imem_valid=1 with discard=0: IR<=imem_rdata, inst_pc<=pc, pc<=pc+1 (mod 2^PC_W, 0xFFFF wraps to 0x0000), go to ISSUE.
  - On imem_valid=1 with discard=1: drop data, clear discard, go to FETCH (or IDLE if run=0).
- ISSUE:
  - inst_valid=1; fields come from IR.
  - If stall=1: hold everything; fields stay stable.
  - If stall=0: the instruction is consumed this cycle. Next state is FETCH if run=1, else IDLE.
- Throughput: with zero-wait memory (imem_valid the cycle after FETCH), one instruction per 3 cycles.
- Latency: from imem_valid to inst_valid=1 is 1 cycle.
- Redirect (redirect_en=1), by state. Redirect takes priority over imem_valid in the same cycle.
  - IDLE/FETCH: pc<=redirect_pc. Any request in FETCH is treated as in flight, so set discard=1 if going to WAIT.
  - WAIT: pc<=redirect_pc, discard<=1. If imem_valid is in the same cycle, drop the data and go to FETCH directly without setting discard.
  - ISSUE: pc<=redirect_pc, inst_valid=0 next cycle, go to FETCH (IDLE if run=0). Stall is ignored.
- run deasserted in FETCH/WAIT: the outstanding fetch completes and is issued, then the FSM goes to IDLE.
- The IR only loads in WAIT on accepted, non-discarded data.
- imem_rdata is ignored when imem_valid=0 or the state is not WAIT.

Test Plan:
- Reset release, run=1, memory returns 0x04400000 one cycle after req:
  - imem_addr=0, then inst_valid=1, opcode=6'b000001, rd=1, inst_pc=0.
  - Next fetch at addr 1.
- Stall held 4 cycles during ISSUE:
  - inst_valid and all fields stable for 4 cycles.
  - No imem_req.
  - Fetch at pc+1 resumes the cycle after stall drops.
- Redirect to 0x0100 while in WAIT, then stale imem_valid arrives 2 cycles later:
  - Stale word never appears (inst_valid stays 0).
  - Next imem_addr=0x0100.
- Redirect and imem_valid in the same cycle: data dropped, FETCH at redirect_pc next cycle.
- PC=0xFFFF fetched: the following fetch uses imem_addr=0x0000.
- rst_n pulsed low while in WAIT:
  - Outputs return to reset values immediately.
  - After release, the first fetch is at RESET_PC.
  - opcode=0 throughout.
